// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and command opcodes.
package counter_seq_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [CMD_W-1:0] {
    OP_START  = 2'd0,
    OP_PAUSE  = 2'd1,
    OP_RESUME = 2'd2,
    OP_ABORT  = 2'd3
  } cmd_op_e;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up counter with asynchronous clear, synchronous zero (priority) and count enable.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             zero,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: zero beats enable
  always_comb begin
    cnt_d = cnt_q;
    if (zero) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an up counter (one-shot / auto-reload, pause/resume/abort).
// Optional tick prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept_s;
  cmd_op_e          op_s;
  logic             tick_s;
  logic             terminal_s;
  logic             cnt_zero_s;
  logic             cnt_en_s;
  logic [WIDTH-1:0] cnt_s;

  assign accept_s   = cmd_valid & ready_q;
  assign op_s       = cmd_op_e'(cmd_op);
  assign terminal_s = (cnt_s == limit_q);

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          presc_clr_s;

  // Prescaler: restarts on START/RESUME/ABORT, free-runs in RUN, holds in PAUSE
  always_comb begin
    presc_clr_s = accept_s && ((op_s == OP_START) ||
                               ((op_s == OP_RESUME) && (state_q == S_PAUSE)) ||
                               ((op_s == OP_ABORT) && (state_q != S_IDLE)));
    tick_s      = (state_q == S_RUN) && (presc_q == PW'(PRESCALE - 1));
    presc_d     = presc_q;
    if (presc_clr_s) begin
      presc_d = {PW{1'b0}};
    end else if (state_q == S_RUN) begin
      presc_d = tick_s ? {PW{1'b0}} : (presc_q + PW'(1));
    end else if (state_q == S_PAUSE) begin
      presc_d = presc_q;
    end else begin
      presc_d = {PW{1'b0}};
    end
  end

  // Prescaler register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Every RUN clock is a tick
  always_comb begin
    tick_s = (state_q == S_RUN);
  end
`endif

  // Next-state and counter control; an accepted effective command overrides a tick
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    reload_d   = reload_q;
    done_d     = 1'b0;
    cnt_zero_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (op_s == OP_START)) begin
          limit_d    = cmd_limit;
          reload_d   = cmd_reload;
          cnt_zero_s = 1'b1;
          state_d    = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_s && (op_s == OP_START)) begin
          limit_d    = cmd_limit;
          reload_d   = cmd_reload;
          cnt_zero_s = 1'b1;
        end else if (accept_s && (op_s == OP_PAUSE)) begin
          state_d = S_PAUSE;
        end else if (accept_s && (op_s == OP_ABORT)) begin
          cnt_zero_s = 1'b1;
          state_d    = S_IDLE;
        end else if (tick_s) begin
          if (terminal_s && reload_q) begin
            cnt_zero_s = 1'b1;
            done_d     = 1'b1;
          end else if (terminal_s) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_en_s = 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (accept_s && (op_s == OP_START)) begin
          limit_d    = cmd_limit;
          reload_d   = cmd_reload;
          cnt_zero_s = 1'b1;
          state_d    = S_RUN;
        end else if (accept_s && (op_s == OP_RESUME)) begin
          state_d = S_RUN;
        end else if (accept_s && (op_s == OP_ABORT)) begin
          cnt_zero_s = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d  = (state_d == S_RUN) || (state_d == S_PAUSE);
    ready_d = (state_d != S_DONE);
  end

  // Control and output registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      limit_q  <= {WIDTH{1'b0}};
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock(clock),
    .clear(clear),
    .zero (cnt_zero_s),
    .en   (cnt_en_s),
    .q    (cnt_s)
  );

  assign q         = cnt_s;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer; expected values are hand-computed.
module tb_counter_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_limit = 4'd0;
  logic       cmd_reload = 1'b0;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic [1:0] state_o;

  int total = 0;
  int bad = 0;

  localparam logic [1:0] OP_START = 2'd0, OP_PAUSE = 2'd1, OP_RESUME = 2'd2, OP_ABORT = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_DONE = 2'd3;

  always #5 clock = ~clock;

  counter_sequencer dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .cmd_reload(cmd_reload),
    .q(q), .busy(busy), .done(done), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] lim, input logic rel);
    cmd_op = op; cmd_limit = lim; cmd_reload = rel; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [1:0] est,
                         input logic ebusy, input logic edone);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_state"}, 32'(state_o), 32'(est));
    chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
    chk({tag, "_done"}, 32'(done), 32'(edone));
  endtask

  initial begin
    #34;
    chk_all("reset", 4'd0, ST_IDLE, 1'b0, 1'b0);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    clear = 1'b0;
    cyc();
`ifdef COUNTER_PRESCALE_EN
    // q advances once every 4 clocks
    cmd(OP_START, 4'd2, 1'b0);
    chk_all("ps_start", 4'd0, ST_RUN, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin cyc(); chk("ps_hold0", 32'(q), 32'd0); end
    cyc(); chk("ps_q1", 32'(q), 32'd1);
    for (int i = 1; i <= 3; i++) begin cyc(); chk("ps_hold1", 32'(q), 32'd1); end
    cyc(); chk("ps_q2", 32'(q), 32'd2);
    for (int i = 1; i <= 3; i++) begin cyc(); chk("ps_hold2", 32'(state_o), 32'(ST_RUN)); end
    cyc(); chk_all("ps_done", 4'd2, ST_DONE, 1'b0, 1'b1);
    cyc(); chk_all("ps_idle", 4'd2, ST_IDLE, 1'b0, 1'b0);
`else
    // 1: one-shot limit 5
    cmd(OP_START, 4'd5, 1'b0);
    chk_all("os_start", 4'd0, ST_RUN, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(); chk_all("os_count", 4'(i), ST_RUN, 1'b1, 1'b0);
    end
    cyc(); chk_all("os_done", 4'd5, ST_DONE, 1'b0, 1'b1);
    chk("os_done_ready", 32'(cmd_ready), 32'd0);
    cyc(); chk_all("os_idle", 4'd5, ST_IDLE, 1'b0, 1'b0);

    // 2: auto-reload limit 3
    cmd(OP_START, 4'd3, 1'b1);
    chk_all("ar_start", 4'd0, ST_RUN, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(); chk_all("ar_count", 4'(k % 4), ST_RUN, 1'b1, (k % 4) == 0);
    end

    // 3: restart limit 9, pause at 2, resume
    cmd(OP_START, 4'd9, 1'b0);
    chk_all("rs_start", 4'd0, ST_RUN, 1'b1, 1'b0);
    cyc(); cyc(); chk("pa_q2", 32'(q), 32'd2);
    cmd(OP_PAUSE, 4'd0, 1'b0);
    chk_all("pa_enter", 4'd2, ST_PAUSE, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin cyc(); chk("pa_hold", 32'(q), 32'd2); end
    cmd(OP_RESUME, 4'd0, 1'b0);
    chk_all("pa_resume", 4'd2, ST_RUN, 1'b1, 1'b0);
    cyc(); chk("pa_tick", 32'(q), 32'd3);

    // 4: abort at q=4
    cyc(); chk("ab_q4", 32'(q), 32'd4);
    cmd(OP_ABORT, 4'd0, 1'b0);
    chk_all("ab_idle", 4'd0, ST_IDLE, 1'b0, 1'b0);
    cyc(); chk_all("ab_after", 4'd0, ST_IDLE, 1'b0, 1'b0);

    // 5: asynchronous clear mid-run
    cmd(OP_START, 4'd9, 1'b0);
    cyc(); cyc(); cyc(); chk("cl_q3", 32'(q), 32'd3);
    #2 clear = 1'b1;
    #1 chk_all("cl_async", 4'd0, ST_IDLE, 1'b0, 1'b0);
    #1 clear = 1'b0;
    cyc();
    cmd(OP_START, 4'd1, 1'b0);
    chk_all("cl_start", 4'd0, ST_RUN, 1'b1, 1'b0);
    cyc(); chk("cl_q1", 32'(q), 32'd1);
    cyc(); chk_all("cl_done", 4'd1, ST_DONE, 1'b0, 1'b1);
    cyc(); chk("cl_idle", 32'(state_o), 32'(ST_IDLE));

    // pause at terminal value: first tick after resume terminates
    cmd(OP_START, 4'd2, 1'b0);
    cyc(); cyc(); chk("pt_q2", 32'(q), 32'd2);
    cmd(OP_PAUSE, 4'd0, 1'b0);
    chk_all("pt_pause", 4'd2, ST_PAUSE, 1'b1, 1'b0);
    cmd(OP_RESUME, 4'd0, 1'b0);
    chk_all("pt_resume", 4'd2, ST_RUN, 1'b1, 1'b0);
    cyc(); chk_all("pt_done", 4'd2, ST_DONE, 1'b0, 1'b1);

    // START offered while in DONE is not accepted
    cmd(OP_START, 4'd7, 1'b0);
    chk_all("dn_ignore", 4'd2, ST_IDLE, 1'b0, 1'b0);

    // 6: limit 0 and limit 15
    cmd(OP_START, 4'd0, 1'b0);
    chk_all("l0_start", 4'd0, ST_RUN, 1'b1, 1'b0);
    cyc(); chk_all("l0_done", 4'd0, ST_DONE, 1'b0, 1'b1);
    cyc(); chk("l0_idle", 32'(state_o), 32'(ST_IDLE));
    cmd(OP_START, 4'd15, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      cyc(); chk_all("l15_count", 4'(i), ST_RUN, 1'b1, 1'b0);
    end
    cyc(); chk_all("l15_done", 4'd15, ST_DONE, 1'b0, 1'b1);
    cyc(); chk_all("l15_idle", 4'd15, ST_IDLE, 1'b0, 1'b0);

    // idle commands have no effect
    cmd(OP_RESUME, 4'd3, 1'b1);
    chk_all("id_resume", 4'd15, ST_IDLE, 1'b0, 1'b0);
    cmd(OP_ABORT, 4'd3, 1'b1);
    chk_all("id_abort", 4'd15, ST_IDLE, 1'b0, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
